ifetch_stage: RTL and testbench
===============================

# ifetch_stage

Instruction-fetch stage of the MIPS pipeline. Holds the program counter, drives the instruction memory address, and latches the returned word plus PC+4 into the IF/ID pipeline register. Fetch-time jump decoding, pipeline stalls, flushes, and branch redirects from EX all enter here. An `imem_ready` handshake lets the uncached memory (tie to 1) and a future cached memory share one interface.

## Interface
- `RESET_PC`, 32'h0, PC loaded on reset.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `stall_in` in 1: hazard unit; freeze PC and IF/ID.
- `flush_in` in 1: clear IF/ID (insert bubble).
- `redirect_valid` in 1: taken branch or other redirect from a later stage.
- `redirect_pc` in 32: redirect target (byte address).
- `imem_address` out 32: byte address to instruction memory; equals `pc` combinationally.
- `imem_data` in 32: instruction word.
- `imem_ready` in 1: `imem_data` valid this cycle.
- `if_id_instr` out 32: latched instruction.
- `if_id_pc_plus4` out 32: latched PC+4 of that instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `fetch_busy` out 1: state is WAIT.
- `perf_fetched` out 32: instructions delivered (macro only).
- `perf_stall_cycles` out 32: stall or wait cycles (macro only).

## Operation
- The FSM has two states:
  - FETCH: access completes this cycle when `imem_ready`=1.
  - WAIT: access outstanding.
- FETCH→WAIT when `imem_ready`=0 and there is no redirect. WAIT→FETCH once `imem_ready`=1.
- Next-PC priority, highest first:
  1. reset: `RESET_PC`.
  2. `redirect_valid`: `redirect_pc`.
  3. `stall_in`, `flush_in`, or `imem_ready`=0: hold `pc`.
  4. Fetched opcode `imem_data[31:26]`=6'b000010 (J): `{pc_plus4[31:28], imem_data[25:0], 2'b00}`.
  5. Otherwise: `pc+4`.
- `pc+4` is modulo 2^32. 32'hFFFFFFFC wraps to 0.
- IF/ID update, highest priority first:
  1. reset: valid=0, instr=0, pc_plus4=0.
  2. `redirect_valid` or `flush_in`: valid=0, instr=0, pc_plus4 held. This applies even if `stall_in`=1.
  3. `stall_in`: all fields hold.
  4. `imem_ready`=0: valid=0, which is a bubble.
  5. Otherwise: instr=`imem_data`, pc_plus4=`pc+4`, valid=1.
- The J instruction itself enters IF/ID. There is no delay slot: the word after J is never fetched.
- A redirect during WAIT abandons the outstanding access. The FSM returns to FETCH and `imem_address` changes on the next cycle. A late `imem_ready` for the old address is ignored.
- The memory is indexed by byte address, and words sit at multiples of 4. The stage never issues an unaligned PC unless `redirect_pc` or `RESET_PC` is unaligned; the stage passes such values through unchanged.

## Timing
- Reset values: `pc`=`RESET_PC`, state=FETCH, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc_plus4`=0, `fetch_busy`=0, perf counters=0.
- Latency: address presented in cycle n with `imem_ready`=1 → IF/ID valid after edge n+1. Throughput is 1 instruction/cycle.
- `imem_address` changes only after a clock edge, never combinationally from inputs.
- `stall_in` at the same time as `imem_ready`=0: state still tracks ready, and IF/ID holds.
- Reset mid-WAIT: returns to FETCH at `RESET_PC` on that edge, with no pending state retained.

## Configuration
- `IFETCH_PERF_CNT_EN` defined:
  - `perf_fetched` increments on every edge that loads IF/ID with valid=1.
  - `perf_stall_cycles` increments on every non-reset edge with `stall_in`=1 or state WAIT/`imem_ready`=0.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Reset with `RESET_PC`=0, memory[0]=J target 4, `imem_ready`=1 → addresses 0, then 16; `if_id_pc_plus4`=4 then 20; `if_id_valid`=1 from the first post-reset edge.
- Straight-line code at 16..32 with no stalls → `imem_address` 16,20,24,28,32 on consecutive cycles; `if_id_instr` follows one cycle behind.
- `stall_in`=1 for 2 cycles at pc=24 → `pc` and IF/ID frozen for 2 cycles, then resume with address 28; with the macro, `perf_stall_cycles`=2.
- `redirect_valid`=1 with `redirect_pc`=76 together with `stall_in`=1 while pc=64 → next address 76; `if_id_valid`=0 for one cycle; the word at 68 never appears in IF/ID.
- `imem_ready` low for 3 cycles at pc=36 → `fetch_busy`=1 for 3 cycles with 3 bubbles; the word at 36 is latched once ready rises; pc then moves to 40.
- Redirect to 16 during WAIT, then a late `imem_ready` → the old word is discarded, the next address is 16, and `perf_fetched` counts only delivered words.

Source files
------------

// File: rtl/ifetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// imem_ready qualifies imem_data; tie high for single-cycle uncached memory.
interface ifetch_stage_if;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic        imem_ready;

    modport master (output imem_address, input imem_data, input imem_ready);
    modport slave  (input imem_address, output imem_data, output imem_ready);
endinterface

// File: rtl/ifetch_stage.sv
// MIPS instruction fetch: PC, fetch-time J decode, IF/ID register; optional perf counters under IFETCH_PERF_CNT_EN.
// Latency: word returned with imem_ready is visible in IF/ID after the next edge; 1 instr/cycle.
// Backpressure: stall_in freezes PC and IF/ID; imem_ready=0 holds PC and inserts bubbles.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  flush_in,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    ifetch_stage_if.master        imem,
    output logic [31:0]           if_id_instr,
    output logic [31:0]           if_id_pc_plus4,
    output logic                  if_id_valid,
    output logic                  fetch_busy,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_stall_cycles
);

    typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_plus4, jump_target;
    logic        is_jump, hold_pc, kill_ifid, load_ifid;

    assign pc_plus4    = pc + 32'd4;
    assign is_jump     = (imem.imem_data[31:26] == 6'b000010);
    assign jump_target = {pc_plus4[31:28], imem.imem_data[25:0], 2'b00};
    assign hold_pc     = stall_in | flush_in | ~imem.imem_ready;
    assign kill_ifid   = redirect_valid | flush_in;
    assign load_ifid   = ~kill_ifid & ~stall_in & imem.imem_ready;

    assign imem.imem_address = pc;
    assign fetch_busy        = (state == WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // A redirect abandons any outstanding access, so a coincident ready is dropped.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_plus4;
        if (redirect_valid || imem.imem_ready)
            state_nxt = FETCH;
        else
            state_nxt = WAIT;

        if (redirect_valid)
            pc_nxt = redirect_pc;
        else if (hold_pc)
            pc_nxt = pc;
        else if (is_jump)
            pc_nxt = jump_target;
        else
            pc_nxt = pc_plus4;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
        end else if (kill_ifid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
        end else if (stall_in) begin
            if_id_valid <= if_id_valid;
        end else if (!imem.imem_ready) begin
            if_id_valid <= 1'b0;
        end else begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem.imem_data;
            if_id_pc_plus4 <= pc_plus4;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched      <= 32'h0;
            perf_stall_cycles <= 32'h0;
        end else begin
            if (load_ifid)
                perf_fetched <= perf_fetched + 32'd1;
            if (stall_in || (state == WAIT) || !imem.imem_ready)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    assign perf_fetched      = 32'h0;
    assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage; imem is a combinational function of the address.
module tb_ifetch_stage;
    logic        clock = 1'b0;
    logic        reset, stall_in, flush_in, redirect_valid, ready;
    logic [31:0] redirect_pc;
    logic [31:0] if_id_instr, if_id_pc_plus4, perf_fetched, perf_stall_cycles;
    logic        if_id_valid, fetch_busy;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] s0, f0;

`ifdef IFETCH_PERF_CNT_EN
    localparam logic [31:0] PERF_STEP = 32'd1;
`else
    localparam logic [31:0] PERF_STEP = 32'd0;
`endif

    ifetch_stage_if bus();

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0)          return 32'h0800_0004;   // J -> 16
        if (a == 32'h5000_0008)  return 32'h0800_0100;   // J -> 0x5000_0400
        return {6'b001000, a[25:0]};
    endfunction

    assign bus.imem_data  = word_at(bus.imem_address);
    assign bus.imem_ready = ready;

    ifetch_stage #(.RESET_PC(32'h0)) dut (
        .clock(clock), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .imem(bus),
        .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid),
        .fetch_busy(fetch_busy), .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (bus.imem_address !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_address, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0", if_id_instr); end
        checks++; if (if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got=%h exp=0", if_id_pc_plus4); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", fetch_busy); end
        checks++; if (perf_fetched !== 32'h0 || perf_stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_fetched, perf_stall_cycles); end
        reset = 1'b0;
        tick();
        checks++; if (bus.imem_address !== 32'd16) begin errors++; $display("FAIL jump_addr got=%h exp=%h", bus.imem_address, 32'd16); end
        checks++; if (if_id_pc_plus4 !== 32'd4) begin errors++; $display("FAIL jump_pcp4 got=%h exp=%h", if_id_pc_plus4, 32'd4); end
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h0800_0004) begin errors++; $display("FAIL jump_ifid got=%b/%h exp=1/08000004", if_id_valid, if_id_instr); end
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a;
            a = 32'd16 + 32'(4 * i);
            checks++; if (bus.imem_address !== a) begin errors++; $display("FAIL seq_addr[%0d] got=%h exp=%h", i, bus.imem_address, a); end
            tick();
            checks++; if (if_id_instr !== word_at(a) || if_id_pc_plus4 !== a + 32'd4) begin errors++; $display("FAIL seq_ifid[%0d] got=%h/%h exp=%h/%h", i, if_id_instr, if_id_pc_plus4, word_at(a), a + 32'd4); end
        end
    endtask

    task automatic test_stall();
        redirect_to(32'd20);
        tick();
        s0 = perf_stall_cycles;
        stall_in = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (bus.imem_address !== 32'd24) begin errors++; $display("FAIL stall_addr[%0d] got=%h exp=%h", k, bus.imem_address, 32'd24); end
            checks++; if (if_id_instr !== word_at(32'd20) || if_id_pc_plus4 !== 32'd24 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid[%0d] got=%h/%h/%b exp=%h/18/1", k, if_id_instr, if_id_pc_plus4, if_id_valid, word_at(32'd20)); end
        end
        stall_in = 1'b0;
        checks++; if (perf_stall_cycles - s0 !== 32'd2 * PERF_STEP) begin errors++; $display("FAIL stall_perf got=%0d exp=%0d", perf_stall_cycles - s0, 32'd2 * PERF_STEP); end
        tick();
        checks++; if (bus.imem_address !== 32'd28 || if_id_instr !== word_at(32'd24)) begin errors++; $display("FAIL stall_resume got=%h/%h exp=1c/%h", bus.imem_address, if_id_instr, word_at(32'd24)); end
    endtask

    task automatic test_redirect();
        redirect_to(32'd64);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd76;
        stall_in       = 1'b1;
        #2;
        checks++; if (bus.imem_address !== 32'd64) begin errors++; $display("FAIL redir_comb_addr got=%h exp=%h", bus.imem_address, 32'd64); end
        tick();
        redirect_valid = 1'b0;
        stall_in       = 1'b0;
        checks++; if (bus.imem_address !== 32'd76) begin errors++; $display("FAIL redir_addr got=%h exp=%h", bus.imem_address, 32'd76); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'd28) begin errors++; $display("FAIL redir_bubble got=%b/%h/%h exp=0/0/1c", if_id_valid, if_id_instr, if_id_pc_plus4); end
        tick();
        checks++; if (if_id_instr !== word_at(32'd76) || if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'd80) begin errors++; $display("FAIL redir_target got=%h/%b/%h exp=%h/1/50", if_id_instr, if_id_valid, if_id_pc_plus4, word_at(32'd76)); end
    endtask

    task automatic test_wait();
        redirect_to(32'd36);
        checks++; if (fetch_busy !== 1'b0 || bus.imem_address !== 32'd36) begin errors++; $display("FAIL wait_pre got=%b/%h exp=0/24", fetch_busy, bus.imem_address); end
        f0 = perf_fetched;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (fetch_busy !== 1'b1 || if_id_valid !== 1'b0 || bus.imem_address !== 32'd36) begin errors++; $display("FAIL wait_cycle[%0d] got=%b/%b/%h exp=1/0/24", k, fetch_busy, if_id_valid, bus.imem_address); end
        end
        ready = 1'b1;
        tick();
        checks++; if (if_id_instr !== word_at(32'd36) || if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'd40) begin errors++; $display("FAIL wait_done_ifid got=%h/%b/%h exp=%h/1/28", if_id_instr, if_id_valid, if_id_pc_plus4, word_at(32'd36)); end
        checks++; if (bus.imem_address !== 32'd40 || fetch_busy !== 1'b0) begin errors++; $display("FAIL wait_done_pc got=%h/%b exp=28/0", bus.imem_address, fetch_busy); end
        checks++; if (perf_fetched - f0 !== PERF_STEP) begin errors++; $display("FAIL wait_perf got=%0d exp=%0d", perf_fetched - f0, PERF_STEP); end
    endtask

    task automatic test_late_ready();
        ready = 1'b0;
        tick();
        checks++; if (fetch_busy !== 1'b1) begin errors++; $display("FAIL late_busy got=%b exp=1", fetch_busy); end
        f0 = perf_fetched;
        ready = 1'b1;
        redirect_to(32'd16);
        checks++; if (bus.imem_address !== 32'd16 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || fetch_busy !== 1'b0) begin errors++; $display("FAIL late_drop got=%h/%b/%h/%b exp=10/0/0/0", bus.imem_address, if_id_valid, if_id_instr, fetch_busy); end
        checks++; if (perf_fetched !== f0) begin errors++; $display("FAIL late_perf_drop got=%0d exp=%0d", perf_fetched, f0); end
        tick();
        checks++; if (if_id_instr !== word_at(32'd16) || bus.imem_address !== 32'd20) begin errors++; $display("FAIL late_next got=%h/%h exp=%h/14", if_id_instr, bus.imem_address, word_at(32'd16)); end
        checks++; if (perf_fetched - f0 !== PERF_STEP) begin errors++; $display("FAIL late_perf got=%0d exp=%0d", perf_fetched - f0, PERF_STEP); end
    endtask

    task automatic test_boundaries();
        redirect_to(32'hFFFF_FFFC);
        tick();
        checks++; if (bus.imem_address !== 32'h0 || if_id_pc_plus4 !== 32'h0 || if_id_instr !== word_at(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap got=%h/%h/%h exp=0/0/%h", bus.imem_address, if_id_pc_plus4, if_id_instr, word_at(32'hFFFF_FFFC)); end
        redirect_to(32'h5000_0008);
        tick();
        checks++; if (bus.imem_address !== 32'h5000_0400 || if_id_pc_plus4 !== 32'h5000_000C || if_id_instr !== 32'h0800_0100) begin errors++; $display("FAIL jump_hi got=%h/%h/%h exp=50000400/5000000c/08000100", bus.imem_address, if_id_pc_plus4, if_id_instr); end
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        checks++; if (bus.imem_address !== 32'h5000_0400 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h5000_000C) begin errors++; $display("FAIL flush got=%h/%b/%h/%h exp=50000400/0/0/5000000c", bus.imem_address, if_id_valid, if_id_instr, if_id_pc_plus4); end
        tick();
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== word_at(32'h5000_0400)) begin errors++; $display("FAIL flush_resume got=%b/%h exp=1/%h", if_id_valid, if_id_instr, word_at(32'h5000_0400)); end
        ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (fetch_busy !== 1'b0 || bus.imem_address !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_mid_wait got=%b/%h/%b/%h exp=0/0/0/0", fetch_busy, bus.imem_address, if_id_valid, if_id_pc_plus4); end
        reset = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
        test_reset();
        test_straight_line();
        test_stall();
        test_redirect();
        test_wait();
        test_late_ready();
        test_boundaries();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
